// File: rtl/pixel_scheduler.sv
// pixel_scheduler
//   Frame-level controller sharing N_ENGINES depth engines across one frame.
//   Raster-scans the frame, derives each pixel's complex constant by
//   incremental add/sub from the latched frame configuration, dispatches
//   each pixel to the lowest free engine and streams results back tagged
//   with their (x,y). Results leave in completion order.
//
// Ports
//   sysclk, reset          clock, synchronous active-high reset (shared with engines)
//   frame_start            one-cycle pulse, starts a frame when idle
//   max_iter_in            iteration limit, latched at frame start
//   re_left/im_top/step    frame geometry, latched at frame start
//   busy, frame_done       frame in progress / one-cycle completion pulse
//   eng_start              per-engine start pulse
//   eng_re_c, eng_im_c     per-engine operands, held while the engine works
//   eng_max_iter           latched iteration limit, broadcast
//   eng_done, eng_depth    per-engine done level and final depth
//   pix_valid/pix_ready    result stream handshake
//   pix_x, pix_y, pix_depth result payload
module pixel_scheduler #(
  parameter int N_ENGINES   = 4,
  parameter int WORD_LENGTH = 32,
  parameter int FRAC        = 28,
  parameter int H_RES       = 640,
  parameter int V_RES       = 480
) (
  input  logic                             sysclk,
  input  logic                             reset,
  input  logic                             frame_start,
  input  logic [9:0]                       max_iter_in,
  input  logic signed [WORD_LENGTH-1:0]    re_left,
  input  logic signed [WORD_LENGTH-1:0]    im_top,
  input  logic signed [WORD_LENGTH-1:0]    step,
  output logic                             busy,
  output logic                             frame_done,
  output logic [N_ENGINES-1:0]             eng_start,
  output logic [N_ENGINES*WORD_LENGTH-1:0] eng_re_c,
  output logic [N_ENGINES*WORD_LENGTH-1:0] eng_im_c,
  output logic [9:0]                       eng_max_iter,
  input  logic [N_ENGINES-1:0]             eng_done,
  input  logic [N_ENGINES*10-1:0]          eng_depth,
  output logic                             pix_valid,
  input  logic                             pix_ready,
  output logic [9:0]                       pix_x,
  output logic [8:0]                       pix_y,
  output logic [9:0]                       pix_depth
);

  localparam int               IDX_W    = (N_ENGINES > 1) ? $clog2(N_ENGINES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ENGINES - 1);
  localparam logic [9:0]       X_LAST   = 10'(H_RES - 1);
  localparam logic [8:0]       Y_LAST   = 9'(V_RES - 1);

  // FRAC only documents the operand format; the datapath is plain wrapping
  // add/sub, so the check below is the only place it matters.
  if (N_ENGINES < 1 || N_ENGINES > 8 || H_RES < 1 || H_RES > 1024 ||
      V_RES < 1 || V_RES > 512 || FRAC >= WORD_LENGTH) begin : g_param_range
    $error("pixel_scheduler: parameter out of range");
  end

  typedef enum logic [1:0] {T_IDLE, T_SCAN, T_DRAIN} top_state_t;
  typedef enum logic [1:0] {S_FREE, S_ARMED, S_BUSY, S_RESULT} slot_state_t;

  top_state_t  top_st;
  slot_state_t slot_st [N_ENGINES];
  logic        slot_guard [N_ENGINES];

  logic [9:0]  scan_x;
  logic [8:0]  scan_y;
  logic [IDX_W-1:0] rr_ptr;
  logic        held_vld;
  logic [IDX_W-1:0] held_idx;

  logic signed [WORD_LENGTH-1:0] re_left_q;
  logic signed [WORD_LENGTH-1:0] step_q;
  logic signed [WORD_LENGTH-1:0] re_acc;
  logic signed [WORD_LENGTH-1:0] im_acc;
  logic signed [WORD_LENGTH-1:0] re_op [N_ENGINES];
  logic signed [WORD_LENGTH-1:0] im_op [N_ENGINES];

  logic [9:0]  slot_x     [N_ENGINES];
  logic [8:0]  slot_y     [N_ENGINES];
  logic [9:0]  slot_depth [N_ENGINES];

  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic             all_free;
  logic             res_found;
  logic [IDX_W-1:0] rr_idx;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] sel_idx;
  logic             handshake;
  logic             dispatch;
  logic             frame_accept;
  logic             x_last;
  logic             y_last;

  // Lowest-indexed free slot wins the next dispatch.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    all_free   = 1'b1;
    for (int k = N_ENGINES - 1; k >= 0; k--) begin
      if (slot_st[k] == S_FREE) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(k);
      end else begin
        all_free = 1'b0;
      end
    end
  end

  // Round-robin search over RESULT slots starting at rr_ptr.
  always_comb begin
    res_found = 1'b0;
    rr_idx    = '0;
    cand      = '0;
    for (int k = 0; k < N_ENGINES; k++) begin
      if (int'(rr_ptr) + k >= N_ENGINES) cand = IDX_W'(int'(rr_ptr) + k - N_ENGINES);
      else                               cand = IDX_W'(int'(rr_ptr) + k);
      if (!res_found && slot_st[cand] == S_RESULT) begin
        res_found = 1'b1;
        rr_idx    = cand;
      end
    end
  end

  // Once a result is offered and refused, the choice is frozen so that a
  // later-finishing slot earlier in search order cannot swap the payload.
  assign sel_idx      = held_vld ? held_idx : rr_idx;
  assign pix_valid    = res_found;
  assign handshake    = pix_valid & pix_ready;
  assign dispatch     = (top_st == T_SCAN) & free_found;
  assign frame_accept = (top_st == T_IDLE) & frame_start;
  assign x_last       = (scan_x == X_LAST);
  assign y_last       = (scan_y == Y_LAST);

  always_comb begin
    pix_x     = '0;
    pix_y     = '0;
    pix_depth = '0;
    if (pix_valid) begin
      pix_x     = slot_x[sel_idx];
      pix_y     = slot_y[sel_idx];
      pix_depth = slot_depth[sel_idx];
    end
  end

  for (genvar g = 0; g < N_ENGINES; g++) begin : g_ops
    assign eng_re_c[g*WORD_LENGTH +: WORD_LENGTH] = re_op[g];
    assign eng_im_c[g*WORD_LENGTH +: WORD_LENGTH] = im_op[g];
  end

  // Control: top FSM, scan counters, slot FSMs, output arbitration.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      top_st       <= T_IDLE;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      eng_start    <= '0;
      eng_max_iter <= '0;
      scan_x       <= '0;
      scan_y       <= '0;
      rr_ptr       <= '0;
      held_vld     <= 1'b0;
      held_idx     <= '0;
      for (int i = 0; i < N_ENGINES; i++) begin
        slot_st[i]    <= S_FREE;
        slot_guard[i] <= 1'b0;
        re_op[i]      <= '0;
        im_op[i]      <= '0;
      end
    end else begin
      frame_done <= 1'b0;
      eng_start  <= '0;

      case (top_st)
        T_IDLE: begin
          if (frame_start) begin
            top_st       <= T_SCAN;
            busy         <= 1'b1;
            scan_x       <= '0;
            scan_y       <= '0;
            eng_max_iter <= max_iter_in;
          end
        end
        T_SCAN: begin
          if (dispatch) begin
            if (x_last) begin
              scan_x <= '0;
              if (y_last) begin
                scan_y <= '0;
                top_st <= T_DRAIN;
              end else begin
                scan_y <= scan_y + 9'd1;
              end
            end else begin
              scan_x <= scan_x + 10'd1;
            end
          end
        end
        T_DRAIN: begin
          if (all_free) begin
            top_st     <= T_IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end
        end
        default: top_st <= T_IDLE;
      endcase

      for (int i = 0; i < N_ENGINES; i++) begin
        case (slot_st[i])
          S_FREE: begin
            if (dispatch && free_idx == IDX_W'(i)) begin
              slot_st[i]    <= S_ARMED;
              slot_guard[i] <= 1'b1;
              eng_start[i]  <= 1'b1;
              re_op[i]      <= re_acc;
              im_op[i]      <= im_acc;
            end
          end
          // The engine still shows its previous done until it has seen
          // start, so done is ignored for two cycles after dispatch.
          S_ARMED: begin
            if (slot_guard[i]) slot_guard[i] <= 1'b0;
            else               slot_st[i]    <= S_BUSY;
          end
          S_BUSY: begin
            if (eng_done[i]) slot_st[i] <= S_RESULT;
          end
          S_RESULT: begin
            if (handshake && sel_idx == IDX_W'(i)) slot_st[i] <= S_FREE;
          end
          default: slot_st[i] <= S_FREE;
        endcase
      end

      if (handshake) begin
        rr_ptr   <= (sel_idx == LAST_IDX) ? '0 : sel_idx + IDX_W'(1);
        held_vld <= 1'b0;
      end else if (pix_valid) begin
        held_vld <= 1'b1;
        held_idx <= sel_idx;
      end
    end
  end

  // Data: frame config latches, coordinate accumulators, slot tags/depths.
  always_ff @(posedge sysclk) begin
    if (frame_accept) begin
      re_left_q <= re_left;
      step_q    <= step;
      re_acc    <= re_left;
      im_acc    <= im_top;
    end else if (dispatch) begin
      if (x_last) begin
        re_acc <= re_left_q;
        im_acc <= im_acc - step_q;
      end else begin
        re_acc <= re_acc + step_q;
      end
    end
    for (int i = 0; i < N_ENGINES; i++) begin
      if (slot_st[i] == S_FREE && dispatch && free_idx == IDX_W'(i)) begin
        slot_x[i] <= scan_x;
        slot_y[i] <= scan_y;
      end
      if (slot_st[i] == S_BUSY && eng_done[i]) begin
        slot_depth[i] <= eng_depth[i*10 +: 10];
      end
    end
  end

endmodule

// File: tb/tb_pixel_scheduler.sv
// tb_pixel_scheduler
//   Directed bench for pixel_scheduler on a 4x2 frame with two engines.
//   Stub engines raise done ten cycles after start with depth 5 and come
//   out of reset with a stale done=1 (depth 0). A manual override on the
//   done/depth lines lets one scenario place completions on exact cycles.
module tb_pixel_scheduler;
  localparam int N  = 2;
  localparam int WL = 32;
  localparam int HR = 4;
  localparam int VR = 2;

  logic                 sysclk = 1'b0;
  logic                 reset = 1'b1;
  logic                 frame_start = 1'b0;
  logic [9:0]           max_iter_in = '0;
  logic signed [WL-1:0] re_left = '0;
  logic signed [WL-1:0] im_top = '0;
  logic signed [WL-1:0] step = '0;
  logic                 busy;
  logic                 frame_done;
  logic [N-1:0]         eng_start;
  logic [N*WL-1:0]      eng_re_c;
  logic [N*WL-1:0]      eng_im_c;
  logic [9:0]           eng_max_iter;
  logic [N-1:0]         eng_done;
  logic [N*10-1:0]      eng_depth;
  logic                 pix_valid;
  logic                 pix_ready = 1'b1;
  logic [9:0]           pix_x;
  logic [8:0]           pix_y;
  logic [9:0]           pix_depth;

  pixel_scheduler #(.N_ENGINES(N), .WORD_LENGTH(WL), .FRAC(28), .H_RES(HR), .V_RES(VR)) dut (
    .sysclk(sysclk), .reset(reset), .frame_start(frame_start), .max_iter_in(max_iter_in),
    .re_left(re_left), .im_top(im_top), .step(step), .busy(busy), .frame_done(frame_done),
    .eng_start(eng_start), .eng_re_c(eng_re_c), .eng_im_c(eng_im_c), .eng_max_iter(eng_max_iter),
    .eng_done(eng_done), .eng_depth(eng_depth), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_depth(pix_depth)
  );

  always #5 sysclk = ~sysclk;

  // Stub engines
  logic [N-1:0]    stub_done;
  logic [N*10-1:0] stub_depth;
  int              stub_cnt [N];
  logic            manual = 1'b0;
  logic [N-1:0]    man_done = '0;
  logic [N*10-1:0] man_depth = '0;

  always @(posedge sysclk) begin
    for (int i = 0; i < N; i++) begin
      if (reset) begin
        stub_done[i]          <= 1'b1;
        stub_depth[i*10 +: 10] <= 10'd0;
        stub_cnt[i]           <= 0;
      end else if (eng_start[i]) begin
        stub_done[i] <= 1'b0;
        stub_cnt[i]  <= 10;
      end else if (stub_cnt[i] != 0) begin
        stub_cnt[i] <= stub_cnt[i] - 1;
        if (stub_cnt[i] == 1) begin
          stub_done[i]           <= 1'b1;
          stub_depth[i*10 +: 10] <= 10'd5;
        end
      end
    end
  end

  assign eng_done  = manual ? man_done  : stub_done;
  assign eng_depth = manual ? man_depth : stub_depth;

  // Monitor: logs dispatches, transfers, frame_done pulses, stability errors.
  logic [WL-1:0] d_re [256];
  logic [WL-1:0] d_im [256];
  logic [9:0]    o_x  [256];
  logic [8:0]    o_y  [256];
  logic [9:0]    o_d  [256];
  int d_cnt = 0, o_cnt = 0, fd_cnt = 0, fd_busy_err = 0, stab_err = 0;
  logic          pv_prev = 1'b0, pr_prev = 1'b1;
  logic [28:0]   out_prev = '0;
  logic [N*WL-1:0] re_prev = '0, im_prev = '0;

  always @(negedge sysclk) begin
    if (frame_done) begin
      fd_cnt++;
      if (busy) fd_busy_err++;
    end
    for (int i = 0; i < N; i++) begin
      if (eng_start[i] && d_cnt < 256) begin
        d_re[d_cnt] = eng_re_c[i*WL +: WL];
        d_im[d_cnt] = eng_im_c[i*WL +: WL];
        d_cnt++;
      end
      if (!reset && !eng_start[i] &&
          (eng_re_c[i*WL +: WL] !== re_prev[i*WL +: WL] ||
           eng_im_c[i*WL +: WL] !== im_prev[i*WL +: WL])) stab_err++;
    end
    if (pix_valid && pix_ready && o_cnt < 256) begin
      o_x[o_cnt] = pix_x;
      o_y[o_cnt] = pix_y;
      o_d[o_cnt] = pix_depth;
      o_cnt++;
    end
    if (!reset && pv_prev && !pr_prev) begin
      if (!pix_valid || {pix_x, pix_y, pix_depth} !== out_prev) stab_err++;
    end
    pv_prev  = pix_valid;
    pr_prev  = pix_ready;
    out_prev = {pix_x, pix_y, pix_depth};
    re_prev  = eng_re_c;
    im_prev  = eng_im_c;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic start_frame(input logic [31:0] rl, input logic [31:0] it,
                             input logic [31:0] st, input logic [9:0] mi);
    re_left     = rl;
    im_top      = it;
    step        = st;
    max_iter_in = mi;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_frame_done(input int fd_base, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      tick();
      if (fd_cnt > fd_base) ok = 1'b1;
    end
  endtask

  // Bitmask of (x,y) positions seen in a slice of the output log; -1 on a
  // duplicate or out-of-range coordinate.
  function automatic int coverage(input int base, input int cnt);
    int m;
    int idx;
    m = 0;
    for (int k = 0; k < cnt; k++) begin
      if (int'(o_x[base+k]) >= HR || int'(o_y[base+k]) >= VR) return -1;
      idx = int'(o_y[base+k]) * HR + int'(o_x[base+k]);
      if (m[idx]) return -1;
      m[idx] = 1'b1;
    end
    return m;
  endfunction

  // Expected operands of the k-th raster pixel: re_left + x*step, im_top - y*step.
  function automatic logic [31:0] exp_re(input logic [31:0] rl, input logic [31:0] st, input int k);
    return rl + 32'(k % HR) * st;
  endfunction
  function automatic logic [31:0] exp_im(input logic [31:0] it, input logic [31:0] st, input int k);
    return it - 32'(k / HR) * st;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge sysclk);
    n_tests++;
    if ({busy, frame_done, eng_start, pix_valid} !== '0) begin
      n_fail++;
      $display("FAIL reset_ctrl: busy/done/start/valid=%b required 0", {busy, frame_done, eng_start, pix_valid});
    end
    n_tests++;
    if ({eng_re_c, eng_im_c, eng_max_iter} !== '0) begin
      n_fail++;
      $display("FAIL reset_operands: re=%h im=%h mi=%0d required 0", eng_re_c, eng_im_c, eng_max_iter);
    end
    n_tests++;
    if ({pix_x, pix_y, pix_depth} !== '0) begin
      n_fail++;
      $display("FAIL reset_payload: x=%0d y=%0d d=%0d required 0", pix_x, pix_y, pix_depth);
    end
    tick();
  endtask

  task automatic test_coordinates();
    int db, ob, fb, bad, cov;
    bit ok;
    db = d_cnt; ob = o_cnt; fb = fd_cnt;
    pix_ready = 1'b1;
    start_frame(32'hE000_0000, 32'h1000_0000, 32'h0080_0000, 10'd100);
    wait_frame_done(fb, 500, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL full_frame_done: no frame_done, required one"); end
    repeat (10) tick();
    n_tests++;
    if (d_cnt - db !== 8) begin n_fail++; $display("FAIL full_dispatch_count: %0d required 8", d_cnt - db); end
    n_tests++;
    if (d_re[db+3] !== 32'hE180_0000 || d_im[db+3] !== 32'h1000_0000) begin
      n_fail++;
      $display("FAIL coord_3_0: re=%h im=%h required E1800000 10000000", d_re[db+3], d_im[db+3]);
    end
    n_tests++;
    if (d_re[db+4] !== 32'hE000_0000 || d_im[db+4] !== 32'h0F80_0000) begin
      n_fail++;
      $display("FAIL coord_0_1: re=%h im=%h required E0000000 0F800000", d_re[db+4], d_im[db+4]);
    end
    bad = 0;
    for (int k = 0; k < 8; k++)
      if (d_re[db+k] !== exp_re(32'hE000_0000, 32'h0080_0000, k) ||
          d_im[db+k] !== exp_im(32'h1000_0000, 32'h0080_0000, k)) bad++;
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL coord_all: %0d wrong operand pairs, required 0", bad); end
    n_tests++;
    if (o_cnt - ob !== 8) begin n_fail++; $display("FAIL full_out_count: %0d required 8", o_cnt - ob); end
    bad = 0;
    for (int k = 0; k < 8; k++) if (o_d[ob+k] !== 10'd5) bad++;
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL full_depth: %0d outputs not depth 5", bad); end
    cov = coverage(ob, 8);
    n_tests++;
    if (cov !== 32'hFF) begin n_fail++; $display("FAIL full_coverage: mask=%0h required ff", cov); end
    n_tests++;
    if (fd_cnt - fb !== 1 || fd_busy_err !== 0) begin
      n_fail++;
      $display("FAIL full_frame_done_pulse: pulses=%0d busy_overlap=%0d required 1 and 0", fd_cnt - fb, fd_busy_err);
    end
    n_tests++;
    if (eng_max_iter !== 10'd100 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL full_end_state: max_iter=%0d busy=%b required 100 and 0", eng_max_iter, busy);
    end
  endtask

  task automatic test_backpressure();
    int db, ob, fb, cov;
    bit ok;
    db = d_cnt; ob = o_cnt; fb = fd_cnt;
    pix_ready = 1'b0;
    start_frame(32'h0000_0000, 32'h0000_0000, 32'h0000_0001, 10'd50);
    repeat (40) tick();
    n_tests++;
    if (d_cnt - db !== N) begin n_fail++; $display("FAIL bp_dispatch_count: %0d required %0d", d_cnt - db, N); end
    @(negedge sysclk);
    n_tests++;
    if (pix_valid !== 1'b1 || {pix_x, pix_y, pix_depth} !== {10'd0, 9'd0, 10'd5}) begin
      n_fail++;
      $display("FAIL bp_held_output: v=%b x=%0d y=%0d d=%0d required 1 0 0 5", pix_valid, pix_x, pix_y, pix_depth);
    end
    n_tests++;
    if (eng_re_c[31:0] !== 32'd0 || eng_re_c[63:32] !== 32'd1) begin
      n_fail++;
      $display("FAIL bp_operands_held: re0=%h re1=%h required 0 1", eng_re_c[31:0], eng_re_c[63:32]);
    end
    tick();
    pix_ready = 1'b1;
    wait_frame_done(fb, 500, ok);
    repeat (3) tick();
    n_tests++;
    if (!ok || o_cnt - ob !== 8) begin
      n_fail++;
      $display("FAIL bp_drain: done=%b outputs=%0d required 1 and 8", ok, o_cnt - ob);
    end
    cov = coverage(ob, 8);
    n_tests++;
    if (cov !== 32'hFF) begin n_fail++; $display("FAIL bp_coverage: mask=%0h required ff", cov); end
    n_tests++;
    if (stab_err !== 0) begin n_fail++; $display("FAIL stability: %0d unstable cycles, required 0", stab_err); end
  endtask

  task automatic test_simultaneous();
    int ob, fb, cov;
    bit ok;
    manual = 1'b1; man_done = 2'b11; man_depth = '0;
    pix_ready = 1'b1;
    ob = o_cnt; fb = fd_cnt;
    start_frame(32'h0000_0000, 32'h0000_0000, 32'h0000_0001, 10'd50);
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge sysclk);
      if (eng_start[0]) ok = 1'b1;
    end
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL sim_first_start: no eng_start[0], required one"); end
    tick();
    man_done = 2'b00;
    repeat (6) tick();
    man_depth[9:0] = 10'd11; man_done[0] = 1'b1;
    tick();
    man_done[0] = 1'b0;
    repeat (6) tick();
    man_depth = {10'd22, 10'd21}; man_done = 2'b11;
    tick();
    manual = 1'b0; man_done = 2'b00;
    repeat (3) tick();
    n_tests++;
    if (o_x[ob] !== 10'd0 || o_y[ob] !== 9'd0 || o_d[ob] !== 10'd11) begin
      n_fail++;
      $display("FAIL sim_first: x=%0d y=%0d d=%0d required 0 0 11", o_x[ob], o_y[ob], o_d[ob]);
    end
    n_tests++;
    if (o_x[ob+1] !== 10'd1 || o_y[ob+1] !== 9'd0 || o_d[ob+1] !== 10'd22) begin
      n_fail++;
      $display("FAIL sim_rr_engine1: x=%0d y=%0d d=%0d required 1 0 22", o_x[ob+1], o_y[ob+1], o_d[ob+1]);
    end
    n_tests++;
    if (o_x[ob+2] !== 10'd2 || o_y[ob+2] !== 9'd0 || o_d[ob+2] !== 10'd21) begin
      n_fail++;
      $display("FAIL sim_rr_engine0: x=%0d y=%0d d=%0d required 2 0 21", o_x[ob+2], o_y[ob+2], o_d[ob+2]);
    end
    wait_frame_done(fb, 500, ok);
    repeat (3) tick();
    cov = coverage(ob, o_cnt - ob);
    n_tests++;
    if (!ok || o_cnt - ob !== 8 || cov !== 32'hFF) begin
      n_fail++;
      $display("FAIL sim_frame: done=%b outputs=%0d mask=%0h required 1 8 ff", ok, o_cnt - ob, cov);
    end
  endtask

  task automatic test_frame_start_ignored();
    int db, fb, bad;
    bit ok;
    db = d_cnt; fb = fd_cnt;
    pix_ready = 1'b1;
    start_frame(32'h7000_0000, 32'hC000_0000, 32'h1000_0000, 10'd77);
    repeat (3) tick();
    start_frame(32'h1111_1111, 32'h2222_2222, 32'h0000_0001, 10'd5);
    n_tests++;
    if (eng_max_iter !== 10'd77) begin n_fail++; $display("FAIL ignore_max_iter: %0d required 77", eng_max_iter); end
    wait_frame_done(fb, 500, ok);
    repeat (20) tick();
    bad = 0;
    for (int k = 0; k < 8; k++)
      if (d_re[db+k] !== exp_re(32'h7000_0000, 32'h1000_0000, k) ||
          d_im[db+k] !== exp_im(32'hC000_0000, 32'h1000_0000, k)) bad++;
    n_tests++;
    if (d_cnt - db !== 8 || bad != 0) begin
      n_fail++;
      $display("FAIL ignore_operands: dispatches=%0d wrong=%0d required 8 and 0", d_cnt - db, bad);
    end
    n_tests++;
    if (!ok || fd_cnt - fb !== 1 || busy !== 1'b0 || eng_max_iter !== 10'd77) begin
      n_fail++;
      $display("FAIL ignore_single_frame: pulses=%0d busy=%b mi=%0d required 1 0 77", fd_cnt - fb, busy, eng_max_iter);
    end
  endtask

  task automatic test_reset_midframe();
    int ob, fb, cov;
    bit ok;
    pix_ready = 1'b1;
    fb = fd_cnt;
    start_frame(32'h0000_0000, 32'h0000_0000, 32'h0000_0001, 10'd9);
    repeat (8) tick();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge sysclk);
    n_tests++;
    if ({busy, eng_start, pix_valid} !== '0) begin
      n_fail++;
      $display("FAIL midreset_state: busy/start/valid=%b required 0", {busy, eng_start, pix_valid});
    end
    repeat (30) tick();
    n_tests++;
    if (fd_cnt !== fb || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_no_done: pulses=%0d busy=%b required 0 and 0", fd_cnt - fb, busy);
    end
    ob = o_cnt;
    start_frame(32'h0000_0000, 32'h0000_0000, 32'h0000_0001, 10'd9);
    wait_frame_done(fb, 500, ok);
    repeat (3) tick();
    cov = coverage(ob, o_cnt - ob);
    n_tests++;
    if (!ok || o_cnt - ob !== 8 || cov !== 32'hFF || fd_cnt - fb !== 1) begin
      n_fail++;
      $display("FAIL midreset_rerun: done=%b outputs=%0d mask=%0h pulses=%0d required 1 8 ff 1",
               ok, o_cnt - ob, cov, fd_cnt - fb);
    end
  endtask

  initial begin
    test_reset();
    test_coordinates();
    test_backpressure();
    test_simultaneous();
    test_frame_start_ignored();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_scheduler.md
Name: pixel_scheduler

Overview:
- Frame-level controller that shares a pool of N_ENGINES depth calculator engines across one full frame.
- Raster-scans pixel coordinates and derives each pixel's complex constant incrementally from frame configuration.
- Dispatches each pixel to a free engine, holds that engine's operands stable until it finishes, and collects results.
- Returns results through a valid/ready stream tagged with x/y; results leave in completion order, not raster order.

Parameters:
N_ENGINES, 4, number of depth engines managed (1..8)
WORD_LENGTH, 32, signed fixed-point operand width
FRAC, 28, fractional bits of operands (documentation only; all arithmetic is plain add/sub)
H_RES, 640, pixels per line (at most 1024)
V_RES, 480, lines per frame (at most 512)

Ports:
sysclk  in  1  clock
reset  in  1  synchronous active-high reset; shared with engines
frame_start  in  1  one-cycle pulse; starts a frame when idle
max_iter_in  in  10  iteration limit, latched at frame_start
re_left  in  WORD_LENGTH  real part at x=0, latched at frame_start
im_top  in  WORD_LENGTH  imaginary part at y=0, latched at frame_start
step  in  WORD_LENGTH  per-pixel increment, latched at frame_start
busy  out  1  frame in progress
frame_done  out  1  one-cycle pulse at frame completion
eng_start  out  N_ENGINES  per-engine start pulse
eng_re_c  out  N_ENGINES*WORD_LENGTH  per-engine real operand, held
eng_im_c  out  N_ENGINES*WORD_LENGTH  per-engine imaginary operand, held
eng_max_iter  out  10  latched iteration limit, broadcast to all engines
eng_done  in  N_ENGINES  per-engine done level
eng_depth  in  N_ENGINES*10  per-engine final depth
pix_valid  out  1  result available
pix_ready  in  1  downstream accepts
pix_x  out  10  result x
pix_y  out  9  result y
pix_depth  out  10  result depth

Behaviour:

Reset:
- All outputs 0.
- Every slot FREE, scan counters 0, round-robin pointer 0, top FSM IDLE.
- Reset mid-frame abandons the frame with no frame_done. Engines reset on the same reset.

Top FSM:
- IDLE -> SCAN on frame_start. The config inputs are latched and busy=1 from the next cycle.
- frame_start is ignored outside IDLE.
- SCAN -> DRAIN in the cycle after pixel (H_RES-1, V_RES-1) is dispatched.
- DRAIN -> IDLE when every slot is FREE. frame_done pulses 1 cycle on this transition and busy drops in the same cycle.

Coordinates:
- re_acc starts at re_left and adds step per dispatched pixel; it reloads re_left on line wrap.
- im_acc starts at im_top and subtracts step per line wrap.
- Arithmetic wraps modulo 2^WORD_LENGTH with no saturation.
- x wraps at H_RES-1 to 0 and increments y.

Dispatch (SCAN only):
- At most one pixel per cycle, to the lowest-indexed FREE slot.
- Operands are registered into that slot's eng_re_c/eng_im_c together with the tag (x,y), and eng_start[i]=1 for exactly that cycle.
- Operands stay constant until the slot returns to FREE.
- No FREE slot means the scan stalls with counters held.

Slot FSM, per engine:
- FREE -> ARMED on dispatch.
- ARMED: a 2-cycle guard during which eng_done is ignored, because the engine clears its stale done only after seeing start. Then -> BUSY.
- BUSY -> RESULT when eng_done[i]=1. eng_depth[i] is captured into the slot in the same cycle.
- RESULT -> FREE on output handshake.
- A slot freed in cycle t is dispatchable no earlier than t+1.

Output:
- pix_valid=1 when any slot is in RESULT.
- Selection is round-robin: the search starts at the pointer, and the pointer moves to the selected index+1 mod N_ENGINES after each handshake.
- pix_x/pix_y/pix_depth are driven combinationally from the selected slot.
- While pix_valid=1 and pix_ready=0, the selected slot and the outputs stay stable.
- Transfer occurs on pix_valid & pix_ready.

Simultaneous events:
- Several engines finishing in one cycle all enter RESULT and are drained in round-robin order.
- A handshake and a dispatch in the same cycle are legal.

Test Plan:
- Reset: hold reset 3 cycles mid-frame, then release -> busy=0, eng_start=0, pix_valid=0, no frame_done; a following frame_start runs normally.
- Coordinates: H_RES=4, V_RES=2, re_left=0xE0000000, im_top=0x10000000, step=0x00800000 -> pixel (3,0) dispatched with re_c=0xE1800000, im_c=0x10000000; pixel (0,1) with re_c=0xE0000000, im_c=0x0F800000.
- Full frame: H_RES=4, V_RES=2, N_ENGINES=2, stub engines (done after 10 cycles, depth 5, stale done=1 before start) -> exactly 8 outputs, each depth 5, each (x,y) exactly once, one frame_done, no early capture of stale done.
- Backpressure: pix_ready=0 for 40 cycles -> at most N_ENGINES pixels dispatched, outputs held stable, nothing lost after pix_ready=1.
- Simultaneous finish: engines 0 and 1 done in the same cycle with pointer=1 -> engine 1 result first, then engine 0.
- frame_start pulsed while busy=1 -> ignored; latched config unchanged for the rest of the frame.
